// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and the schedulers that sit in front of it.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;
    // Wide enough to hold every value from 0 up to and including FIFO_DEPTH.
    localparam int FIFO_LVL_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted valid bit at or above ptr, wrapping.
// Purely combinational so the read-side scheduler can reuse it.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // Scan NUM_REQ candidates starting at ptr; the first valid one wins.
    always_comb begin
        int c;
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        c     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && valid[IDX_W'(c)]) begin
                found = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-port scheduler for the team FIFO: round-robin arbitration with burst
// lock, credit-counted occupancy and a registered write interface.
module fifo_wr_sched
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int LVL_W   = FIFO_LVL_W
) (
    input  logic                      inp_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_d,
    input  logic                      fifo_rd_en,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic [2:0]                grant_id,
    output logic                      underflow_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    sched_state_e       state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               space;
    logic               grant_ok;
    logic               xfer;
    logic               pop_ok;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // No bypass: a pop only frees space once the level register has updated.
    assign space    = (fifo_level < DEPTH_L);
    assign grant_ok = sel_found && space && !reset;
    assign xfer     = |(req_valid & req_ready);
    assign pop_ok   = fifo_rd_en && (fifo_level != '0);

    assign fifo_full  = (fifo_level == DEPTH_L);
    assign fifo_empty = (fifo_level == '0);

    // Candidate selection: the locked owner during a burst, else the rr winner.
    always_comb begin
        sel_idx   = (state == ST_BURST) ? owner : pick_idx;
        sel_found = (state == ST_BURST) || pick_found;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_last = req_last[i];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge inp_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: a non-last beat locks the port, a last beat releases it.
    always_comb begin
        state_nxt = state;
        if (xfer) state_nxt = sel_last ? ST_IDLE : ST_BURST;
    end

    // FSM outputs: at most the selected requester sees ready, and only with space.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_ok && (sel_idx == IDX_W'(i));
        end
    end

    // Arbitration bookkeeping: burst owner and round-robin pointer.
    always_ff @(posedge inp_clk) begin
        if (reset) begin
            rr_ptr <= '0;
            owner  <= '0;
        end else if (xfer) begin
            owner <= sel_idx;
            if (sel_last) rr_ptr <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
        end
    end

    // Registered write interface towards the FIFO, one cycle after acceptance.
    always_ff @(posedge inp_clk) begin
        if (reset) begin
            fifo_wr_en <= 1'b0;
            fifo_wr_d  <= '0;
            grant_id   <= '0;
        end else begin
            fifo_wr_en <= xfer;
            if (xfer) begin
                fifo_wr_d <= sel_data;
                grant_id  <= 3'(sel_idx);
            end
        end
    end

    // Credit counter and sticky underflow flag.
    always_ff @(posedge inp_clk) begin
        if (reset) begin
            fifo_level    <= '0;
            underflow_err <= 1'b0;
        end else begin
            case ({xfer, pop_ok})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (fifo_rd_en && (fifo_level == '0)) underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched with a cycle-level reference model.
module tb_fifo_wr_sched;

    logic        inp_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_d;
    logic        fifo_rd_en;
    logic [4:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;
    logic [2:0]  grant_id;
    logic        underflow_err;

    fifo_wr_sched #(.NUM_REQ(4), .DATA_W(8), .DEPTH(16), .LVL_W(5)) dut (
        .inp_clk       (inp_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_d     (fifo_wr_d),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_level    (fifo_level),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .grant_id      (grant_id),
        .underflow_err (underflow_err)
    );

    always #5 inp_clk = ~inp_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, described in terms of the scheduling rules.
    int       m_level  = 0;
    int       m_rr     = 0;
    bit       m_locked = 0;
    int       m_owner  = 0;
    bit       m_wr_en  = 0;
    int       m_wr_d   = 0;
    int       m_grant  = 0;
    bit       m_uf     = 0;
    logic [3:0] exp_ready;
    bit       m_xfer;
    int       m_idx;

    logic [3:0] ready_seen;
    int         glog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Who may write this cycle: the burst owner, otherwise the first valid
    // requester counting upward from the pointer; nobody when full or in reset.
    task automatic model_comb();
        bit found = 0;
        m_idx = 0;
        if (m_locked) begin
            found = 1;
            m_idx = m_owner;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int j = (m_rr + k) % 4;
                if (!found && req_valid[j]) begin
                    found = 1;
                    m_idx = j;
                end
            end
        end
        if (found && (m_level < 16) && !reset) begin
            exp_ready = 4'b0001 << m_idx;
            m_xfer    = req_valid[m_idx];
        end else begin
            exp_ready = 4'b0000;
            m_xfer    = 0;
        end
    endtask

    task automatic model_seq();
        if (reset) begin
            m_level = 0; m_rr = 0; m_locked = 0; m_owner = 0;
            m_wr_en = 0; m_wr_d = 0; m_grant = 0; m_uf = 0;
        end else begin
            int delta = 0;
            m_wr_en = m_xfer;
            if (m_xfer) begin
                m_wr_d  = int'(req_data[m_idx*8 +: 8]);
                m_grant = m_idx;
                if (req_last[m_idx]) begin
                    m_locked = 0;
                    m_rr     = (m_idx + 1) % 4;
                end else begin
                    m_locked = 1;
                    m_owner  = m_idx;
                end
                delta = delta + 1;
            end
            if (fifo_rd_en) begin
                if (m_level == 0) m_uf = 1;
                else delta = delta - 1;
            end
            m_level = m_level + delta;
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic rd, input logic rst);
        req_valid  = v;
        req_last   = l;
        fifo_rd_en = rd;
        reset      = rst;
        req_data   = $urandom;
    endtask

    // One clock: compare combinational ready mid-cycle, registered outputs
    // just after the edge, and return on the following falling edge.
    task automatic cycle();
        #1;
        model_comb();
        ready_seen = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge inp_clk);
        model_seq();
        #1;
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
        check("fifo_wr_d", 32'(fifo_wr_d), 32'(m_wr_d));
        check("grant_id", 32'(grant_id), 32'(m_grant));
        check("fifo_level", 32'(fifo_level), 32'(m_level));
        check("fifo_full", 32'(fifo_full), 32'(m_level == 16));
        check("fifo_empty", 32'(fifo_empty), 32'(m_level == 0));
        check("underflow_err", 32'(underflow_err), 32'(m_uf));
        if (fifo_wr_en === 1'b1) glog.push_back(int'(grant_id));
        @(negedge inp_clk);
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        cycle();
        glog.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_burst[4] = '{2, 2, 2, 0};

        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        @(negedge inp_clk);

        // Reset state.
        do_reset();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);

        // Single word from requester 1.
        drive(4'b0010, 4'b0010, 1'b0, 1'b0);
        req_data[15:8] = 8'h08;
        cycle();
        check("t1_ready", 32'(ready_seen), 32'h2);
        check("t1_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t1_wr_d", 32'(fifo_wr_d), 32'h08);
        check("t1_grant", 32'(grant_id), 32'd1);
        check("t1_level", 32'(fifo_level), 32'd1);

        // All four valid, single-word transfers: strict rotation, no bubbles.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 4'b1111, 1'b0, 1'b0);
            cycle();
        end
        check("t2_count", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            check("t2_order", 32'(glog[i]), 32'(exp_order[i]));
        check("t2_level", 32'(fifo_level), 32'd8);

        // Burst lock: requester 2 holds the port even while it drops valid.
        do_reset();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0);
        cycle();
        glog.delete();
        drive(4'b0101, 4'b0001, 1'b0, 1'b0); cycle();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); cycle();
        check("t3_locked_ready", 32'(ready_seen), 32'h4);
        check("t3_gap_wr_en", 32'(fifo_wr_en), 32'd0);
        drive(4'b0101, 4'b0001, 1'b0, 1'b0); cycle();
        drive(4'b0101, 4'b0101, 1'b0, 1'b0); cycle();
        drive(4'b0001, 4'b0001, 1'b0, 1'b0); cycle();
        check("t3_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check("t3_order", 32'(glog[i]), 32'(exp_burst[i]));

        // Full boundary and recovery after a single pop.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(4'b0010, 4'b0010, 1'b0, 1'b0);
            cycle();
        end
        check("t4_level_full", 32'(fifo_level), 32'd16);
        check("t4_full", 32'(fifo_full), 32'd1);
        drive(4'b0010, 4'b0010, 1'b1, 1'b0); cycle();
        check("t4_ready_at_full", 32'(ready_seen), 32'h0);
        check("t4_level_pop", 32'(fifo_level), 32'd15);
        drive(4'b0010, 4'b0010, 1'b0, 1'b0); cycle();
        check("t4_ready_back", 32'(ready_seen), 32'h2);
        check("t4_level_refill", 32'(fifo_level), 32'd16);

        // Simultaneous push and pop, then drain and underflow.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0001, 4'b0001, 1'b0, 1'b0);
            cycle();
        end
        drive(4'b0001, 4'b0001, 1'b1, 1'b0); cycle();
        check("t5_level_same", 32'(fifo_level), 32'd5);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0000, 4'b0000, 1'b1, 1'b0);
            cycle();
        end
        check("t5_drained", 32'(fifo_level), 32'd0);
        check("t5_no_uf_yet", 32'(underflow_err), 32'd0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b0); cycle();
        check("t5_uf_set", 32'(underflow_err), 32'd1);
        check("t5_level_zero", 32'(fifo_level), 32'd0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); cycle();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); cycle();
        check("t5_uf_sticky", 32'(underflow_err), 32'd1);

        // Reset during the second beat of a burst.
        do_reset();
        drive(4'b1000, 4'b0000, 1'b0, 1'b0); cycle();
        check("t6_first_grant", 32'(grant_id), 32'd3);
        drive(4'b1001, 4'b0000, 1'b0, 1'b1); cycle();
        check("t6_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        drive(4'b1001, 4'b1111, 1'b0, 1'b0); cycle();
        check("t6_restart_ready", 32'(ready_seen), 32'h1);
        check("t6_restart_grant", 32'(grant_id), 32'd0);
        check("t6_restart_level", 32'(fifo_level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
